// File: rtl/m3_slice_timer_pkg.sv
// rtl/m3_slice_timer_pkg.sv - shared constants, state encoding and step helper for the slice timer
package m3_slice_timer_pkg;

  localparam int unsigned SLICE_PERIOD_MIN = 40;
  localparam int unsigned SLICE_PERIOD_MAX = 2_000_000;
  localparam logic [2:0]  SLICE_LAST       = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // Commutation step, wrapping inside 0..5 in either direction.
  function automatic logic [2:0] step_idx(input logic [2:0] idx, input logic rev);
    if (rev)
      return (idx == 3'd0) ? SLICE_LAST : idx - 3'd1;
    else
      return (idx == SLICE_LAST) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/m3_slice_cnt.sv
// rtl/m3_slice_cnt.sv - loadable down-counter with zero flag
module m3_slice_cnt #(
  parameter int PERIOD_W = 32
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] load_val,
  output logic [PERIOD_W-1:0] count,
  output logic                zero
);

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/m3_slice_timer.sv
// rtl/m3_slice_timer.sv - turns the target slice period into six-slice commutation strobes
module m3_slice_timer
  import m3_slice_timer_pkg::*;
#(
  parameter int          PERIOD_W  = 32,
  parameter int unsigned SLICE_MIN = SLICE_PERIOD_MIN,
  parameter int unsigned SLICE_MAX = SLICE_PERIOD_MAX
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                workingI,
  input  logic                m3forceStopI,
  input  logic                m3invRotateI,
  input  logic [PERIOD_W-1:0] dstRoundLenI,
  output logic                sliceStrobeO,
  output logic [2:0]          sliceIdxO,
  output logic                nextRound_1O,
  output logic [PERIOD_W-1:0] curLenO,
  output logic                runningO
);

  localparam logic [PERIOD_W-1:0] MIN_V = PERIOD_W'(SLICE_MIN);
  localparam logic [PERIOD_W-1:0] MAX_V = PERIOD_W'(SLICE_MAX);

  state_t              state, state_nxt;
  logic [2:0]          slot, slot_nxt, idx_nxt;
  logic                rev;
  logic                latch, strobe_nxt, round_nxt;
  logic                cnt_load, cnt_en, cnt_zero;
  logic [PERIOD_W-1:0] cnt_val, cnt, clamped, len_nxt;

  always_comb begin
    if (dstRoundLenI < MIN_V)
      clamped = MIN_V;
    else if (dstRoundLenI > MAX_V)
      clamped = MAX_V;
    else
      clamped = dstRoundLenI;
  end

  m3_slice_cnt #(.PERIOD_W(PERIOD_W)) u_cnt (
    .clkI     (clkI),
    .nRstI    (nRstI),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch      = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_val    = curLenO - 1'b1;
    strobe_nxt = 1'b0;
    round_nxt  = 1'b0;
    idx_nxt    = sliceIdxO;
    slot_nxt   = slot;

    case (state)
      ST_IDLE, ST_STOP: begin
        if (workingI && !m3forceStopI)
          state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        latch     = 1'b1;
        cnt_load  = 1'b1;
        cnt_val   = clamped - 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_zero) begin
          strobe_nxt = 1'b1;
          idx_nxt    = step_idx(sliceIdxO, rev);
          slot_nxt   = (slot == SLICE_LAST) ? 3'd0 : slot + 3'd1;
          cnt_load   = 1'b1;
          // Round boundary: the freshly clamped period drives the very next slice.
          if (slot == SLICE_LAST) begin
            round_nxt = 1'b1;
            latch     = 1'b1;
            cnt_val   = clamped - 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (m3forceStopI && (state == ST_LOAD || state == ST_RUN)) begin
      state_nxt  = ST_STOP;
      latch      = 1'b0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      strobe_nxt = 1'b0;
      round_nxt  = 1'b0;
      idx_nxt    = sliceIdxO;
      slot_nxt   = slot;
    end

    if (!workingI) begin
      state_nxt  = ST_IDLE;
      latch      = 1'b0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      strobe_nxt = 1'b0;
      round_nxt  = 1'b0;
      idx_nxt    = 3'd0;
      slot_nxt   = 3'd0;
    end

    if (latch)
      len_nxt = clamped;
    else if (state_nxt == ST_IDLE)
      len_nxt = MAX_V;
    else
      len_nxt = curLenO;
  end

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      sliceStrobeO <= 1'b0;
      nextRound_1O <= 1'b0;
      sliceIdxO    <= 3'd0;
      slot         <= 3'd0;
      curLenO      <= MAX_V;
      runningO     <= 1'b0;
      rev          <= 1'b0;
    end else begin
      sliceStrobeO <= strobe_nxt;
      nextRound_1O <= round_nxt;
      sliceIdxO    <= idx_nxt;
      slot         <= slot_nxt;
      curLenO      <= len_nxt;
      runningO     <= (state_nxt == ST_RUN);
      if (latch)
        rev <= m3invRotateI;
    end
  end

endmodule
